// File: rtl/fifo_reader_if.sv
// fifo_reader_if: groups the FIFO read-side pins, the write-accept pulse and the
// downstream valid/ready stream of fifo_reader into one bundle.
// master = the reader controller, slave = its surroundings (FIFO + consumer).
interface fifo_reader_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             wr_seen;
   logic             en_read;
   logic [WIDTH-1:0] fifo_data;
   logic             underflow;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   logic [CW-1:0]    count;
   logic             err;
   logic             err_clr;

   modport master (
      input  wr_seen, fifo_data, underflow, m_ready, err_clr,
      output en_read, m_data, m_valid, count, err
   );

   modport slave (
      output wr_seen, fifo_data, underflow, m_ready, err_clr,
      input  en_read, m_data, m_valid, count, err
   );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the 8-bit synchronous FIFO. Mirrors FIFO
// occupancy from accepted writes, pops only when a word is present and soaks up
// the FIFO's one-cycle read latency in a 2-entry skid buffer feeding a
// valid/ready stream. Any mirror overflow or returned underflow halts reads
// until err_clr.
module fifo_reader #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input logic           clk,
   input logic           reset,
   fifo_reader_if.master bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e           state_q;
   logic             err_q;
   logic [CW-1:0]    count_q, count_d;
   logic             inflight_q;
   logic [WIDTH-1:0] mem_q [2];
   logic             rd_ptr_q, wr_ptr_q;
   logic [1:0]       buf_cnt_q, buf_cnt_d;

   logic valid;
   logic pop;
   logic push;
   logic en_read;
   logic mirror_ovf;
   logic read_err;

   assign valid = (buf_cnt_q != 2'd0);
   assign pop   = valid && bus.m_ready;
   // A word returned alongside underflow is garbage and never enters the buffer.
   assign push  = inflight_q && !bus.underflow;
   assign read_err = inflight_q && bus.underflow;

   // Words held plus the word in flight, less this cycle's pop, must leave a free slot.
   assign en_read = (state_q == StRun) && (count_q != '0) &&
                    (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

   assign buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};

   // Mirror occupancy: +1 per accepted write, -1 per pop, saturating at DEPTH.
   always_comb begin
      count_d    = count_q;
      mirror_ovf = 1'b0;
      if (bus.wr_seen && !en_read) begin
         if (count_q == CW'(DEPTH)) begin
            mirror_ovf = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (!bus.wr_seen && en_read) begin
         count_d = count_q - CW'(1);
      end
   end

   // Occupancy mirror and read-in-flight tracking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         inflight_q <= en_read;
      end
   end

   // Two-entry skid buffer: written at the tail when a read returns, read from the head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         buf_cnt_q <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= bus.fifo_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         buf_cnt_q <= buf_cnt_d;
      end
   end

   // Run/halt control with registered sticky error; a fresh error beats err_clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StRun;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mirror_ovf || read_err) begin
                  state_q <= StHalt;
                  err_q   <= 1'b1;
               end
            end
            StHalt: begin
               if (bus.err_clr && !(mirror_ovf || read_err)) begin
                  state_q <= StRun;
                  err_q   <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.en_read = en_read;
   assign bus.m_valid = valid;
   assign bus.m_data  = mem_q[rd_ptr_q];
   assign bus.count   = count_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: drives fifo_reader with a FIFO model and checks every cycle
// against a queue-based reference of the reader's behaviour.
module tb_fifo_reader;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = $clog2(DEPTH + 1);
   localparam int unsigned VW    = WIDTH + CW + 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fifo_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   fifo_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_en  = 0;

   // Reference state: FIFO contents, skid contents, mirror count, in-flight word.
   logic [WIDTH-1:0] fifo_q [$];
   logic [WIDTH-1:0] m_buf [$];
   logic [WIDTH-1:0] sent_q [$];
   logic [WIDTH-1:0] got_q [$];
   int               m_count = 0;
   bit               m_infl = 1'b0;
   bit               m_err = 1'b0;
   logic [WIDTH-1:0] m_infl_word = '0;
   logic [WIDTH-1:0] wr_word = '0;
   bit               exp_en;
   logic [VW-1:0]    exp_vec;

   wire [VW-1:0] dut_vec = {bus.en_read, bus.m_valid,
                            bus.m_valid ? bus.m_data : {WIDTH{1'b0}}, bus.count, bus.err};

   function automatic void eval_model();
      bit v;
      bit p;
      int slots;
      v     = (m_buf.size() != 0);
      p     = v && bus.m_ready;
      slots = m_buf.size() + int'(m_infl) - int'(p);
      exp_en  = !m_err && (m_count != 0) && (slots < 2);
      exp_vec = {exp_en, v, v ? m_buf[0] : {WIDTH{1'b0}}, CW'(m_count), m_err};
   endfunction

   function automatic void model_edge();
      bit pop_m;
      bit uf;
      bit ovf;
      pop_m = (m_buf.size() != 0) && bus.m_ready;
      uf    = m_infl && bus.underflow;
      ovf   = 1'b0;
      if (pop_m) void'(m_buf.pop_front());
      if (m_infl && !bus.underflow) m_buf.push_back(m_infl_word);
      if (bus.wr_seen && !exp_en) begin
         if (m_count == DEPTH) ovf = 1'b1;
         else m_count++;
      end else if (!bus.wr_seen && exp_en) begin
         m_count--;
      end
      if (exp_en) begin
         if (fifo_q.size() != 0) m_infl_word = fifo_q.pop_front();
         else m_infl_word = WIDTH'($urandom);
      end
      if (bus.wr_seen && fifo_q.size() < DEPTH) begin
         fifo_q.push_back(wr_word);
         sent_q.push_back(wr_word);
      end
      m_infl = exp_en;
      if (ovf || uf) m_err = 1'b1;
      else if (bus.err_clr) m_err = 1'b0;
   endfunction

   function automatic void model_reset();
      fifo_q.delete();
      m_buf.delete();
      m_count     = 0;
      m_infl      = 1'b0;
      m_err       = 1'b0;
      m_infl_word = '0;
   endfunction

   // Advance one clock: log DUT transfers/reads, update the model, FIFO drives data.
   task automatic tick();
      eval_model();
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      if (bus.en_read) n_en++;
      @(posedge clk);
      model_edge();
      #1 bus.fifo_data = m_infl_word;
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive(input bit wr, input bit rdy, input bit uf, input bit clr);
      bus.wr_seen   = wr;
      bus.m_ready   = rdy;
      bus.underflow = uf;
      bus.err_clr   = clr;
      wr_word       = WIDTH'($urandom);
   endtask

   task automatic test_reset();
      logic [VW-1:0] raw;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      bus.fifo_data = '0;
      raw = {bus.en_read, bus.m_valid, bus.m_data, bus.count, bus.err};
      total++;
      if (raw !== '0) begin
         bad++;
         $display("FAIL reset_async got=%h want=0", raw);
      end
      repeat (2) @(negedge clk);
      raw = {bus.en_read, bus.m_valid, bus.m_data, bus.count, bus.err};
      total++;
      if (raw !== '0) begin
         bad++;
         $display("FAIL reset_hold got=%h want=0", raw);
      end
      reset = 1'b1;
      #1;
      eval_model();
      total++;
      if (dut_vec !== exp_vec) begin
         bad++;
         $display("FAIL reset_release got=%h want=%h", dut_vec, exp_vec);
      end
      @(negedge clk);
   endtask

   task automatic test_in_order();
      logic [WIDTH-1:0] words [3];
      int first_valid;
      words = '{8'h24, 8'h81, 8'h09};
      first_valid = -1;
      got_q.delete();
      sent_q.delete();
      n_en = 0;
      for (int i = 0; i < 12; i++) begin
         drive(i < 3, 1'b1, 1'b0, 1'b0);
         if (i < 3) wr_word = words[i];
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL in_order cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         if (bus.m_valid && first_valid < 0) first_valid = i;
         tick();
      end
      total++;
      if (n_en != 3) begin
         bad++;
         $display("FAIL in_order_reads got=%0d want=3", n_en);
      end
      total++;
      if (first_valid != 3) begin
         bad++;
         $display("FAIL in_order_latency got=%0d want=3", first_valid);
      end
      total++;
      if (got_q.size() != 3 || got_q[0] !== 8'h24 || got_q[1] !== 8'h81 || got_q[2] !== 8'h09)
      begin
         bad++;
         $display("FAIL in_order_data got_n=%0d want=24,81,09", got_q.size());
      end
      total++;
      if (bus.count !== CW'(0)) begin
         bad++;
         $display("FAIL in_order_count got=%0d want=0", bus.count);
      end
   endtask

   task automatic test_streaming();
      int first;
      int last;
      bit ok;
      first = -1;
      last  = -1;
      got_q.delete();
      sent_q.delete();
      n_en = 0;
      for (int i = 0; i < 24; i++) begin
         drive(i < 15, 1'b1, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL stream cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         if (bus.m_valid && bus.m_ready) begin
            if (first < 0) first = i;
            last = i;
         end
         tick();
      end
      total++;
      if (n_en != 15 || last - first + 1 != 15) begin
         bad++;
         $display("FAIL stream_rate reads=%0d span=%0d want=15,15", n_en, last - first + 1);
      end
      ok = (got_q.size() == 15) && (sent_q.size() == 15);
      if (ok) for (int k = 0; k < 15; k++) if (got_q[k] !== sent_q[k]) ok = 1'b0;
      total++;
      if (!ok || bus.err !== 1'b0) begin
         bad++;
         $display("FAIL stream_order got_n=%0d want_n=15 err=%b", got_q.size(), bus.err);
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] head;
      bit ok;
      got_q.delete();
      sent_q.delete();
      n_en = 0;
      for (int i = 0; i < 10; i++) begin
         drive(i < 5, 1'b0, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL backpr_hold cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      head = bus.m_data;
      total++;
      if (n_en != 2 || bus.count !== CW'(3) || head !== sent_q[0]) begin
         bad++;
         $display("FAIL backpr_stall reads=%0d count=%0d head=%h want=2,3,%h",
                  n_en, bus.count, head, sent_q[0]);
      end
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL backpr_drain cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      ok = (got_q.size() == 5);
      if (ok) for (int k = 0; k < 5; k++) if (got_q[k] !== sent_q[k]) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL backpr_order got_n=%0d want_n=5", got_q.size());
      end
   endtask

   task automatic test_overflow();
      bit ok;
      got_q.delete();
      sent_q.delete();
      n_en = 0;
      for (int i = 0; i < 23; i++) begin
         drive(i < 19, 1'b0, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL ovf_fill cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      total++;
      if (bus.err !== 1'b1 || bus.count !== CW'(DEPTH) || n_en != 2 || bus.en_read !== 1'b0) begin
         bad++;
         $display("FAIL ovf_halt err=%b count=%0d reads=%0d en=%b want=1,16,2,0",
                  bus.err, bus.count, n_en, bus.en_read);
      end
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 1'b1, 1'b0, i == 0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL ovf_resume cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      ok = (got_q.size() == 18) && (sent_q.size() == 18);
      if (ok) for (int k = 0; k < 18; k++) if (got_q[k] !== sent_q[k]) ok = 1'b0;
      total++;
      if (!ok || bus.err !== 1'b0 || bus.count !== CW'(0)) begin
         bad++;
         $display("FAIL ovf_drain got_n=%0d err=%b count=%0d want=18,0,0",
                  got_q.size(), bus.err, bus.count);
      end
   endtask

   task automatic test_underflow_reset();
      logic [VW-1:0] raw;
      got_q.delete();
      sent_q.delete();
      n_en = 0;
      for (int i = 0; i < 6; i++) begin
         drive(i == 0, 1'b1, i == 2, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL uflow cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      total++;
      if (bus.err !== 1'b1 || got_q.size() != 0 || n_en != 1) begin
         bad++;
         $display("FAIL uflow_discard err=%b got_n=%0d reads=%0d want=1,0,1",
                  bus.err, got_q.size(), n_en);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(i < 2, 1'b0, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL rst_fill cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      total++;
      if (bus.m_valid !== 1'b1 || bus.err !== 1'b0) begin
         bad++;
         $display("FAIL rst_prefill valid=%b err=%b want=1,0", bus.m_valid, bus.err);
      end
      #2 reset = 1'b0;
      #1;
      model_reset();
      bus.fifo_data = '0;
      raw = {bus.en_read, bus.m_valid, bus.m_data, bus.count, bus.err};
      total++;
      if (raw !== '0) begin
         bad++;
         $display("FAIL rst_mid got=%h want=0", raw);
      end
      @(negedge clk);
      reset = 1'b1;
      got_q.delete();
      sent_q.delete();
      n_en = 0;
      for (int i = 0; i < 6; i++) begin
         drive(i == 0, 1'b1, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL rst_resume cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      total++;
      if (got_q.size() != 1 || n_en != 1 || got_q[0] !== sent_q[0]) begin
         bad++;
         $display("FAIL rst_single got_n=%0d reads=%0d want=1,1", got_q.size(), n_en);
      end
   endtask

   task automatic test_random();
      bit ok;
      got_q.delete();
      sent_q.delete();
      for (int i = 0; i < 430; i++) begin
         if (i < 400) drive(($urandom_range(1) == 1) && (m_count < DEPTH),
                            $urandom_range(9) < 7, 1'b0, 1'b0);
         else drive(1'b0, 1'b1, 1'b0, 1'b0);
         #1;
         eval_model();
         total++;
         if (dut_vec !== exp_vec) begin
            bad++;
            $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec, exp_vec);
         end
         tick();
      end
      ok = (got_q.size() == sent_q.size());
      if (ok) for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== sent_q[k]) ok = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL random_order got_n=%0d want_n=%0d", got_q.size(), sent_q.size());
      end
   endtask

   initial begin
      bus.wr_seen   = 1'b0;
      bus.m_ready   = 1'b0;
      bus.underflow = 1'b0;
      bus.err_clr   = 1'b0;
      bus.fifo_data = '0;
      @(negedge clk);
      test_reset();
      test_in_order();
      test_streaming();
      test_backpressure();
      test_overflow();
      test_underflow_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
